m68k_bus_responder: RTL and testbench

// - 68000 bus target. The Amiga (or another bus master) initiates cycles; this block terminates them.
// - Decodes AS/UDS/LDS/RnW cycles that hit a small word-addressed mailbox window.
// - Read cycles: returns mailbox data. Write cycles: commits bytes to the mailbox.
// - Terminates every hit cycle by driving nDTACK low.
// - Pi side reads and writes the same mailbox through a simple register port.

---
 rtl/m68k_bus_responder_if.sv | 23 ++
 rtl/m68k_bus_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_m68k_bus_responder.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m68k_bus_responder_if.sv
// 68000 bus signals between a bus master and the mailbox responder.
// The master drives address, data and strobes; the responder returns read data, data enable and DTACK.
interface m68k_bus_responder_if;
    logic [23:1] BUS_A;
    logic [15:0] BUS_D_IN;
    logic        BUS_nAS;
    logic        BUS_nUDS;
    logic        BUS_nLDS;
    logic        BUS_RnW;
    logic [15:0] BUS_D_OUT;
    logic        BUS_D_OE;
    logic        BUS_nDTACK_OE;

    modport master (
        output BUS_A, BUS_D_IN, BUS_nAS, BUS_nUDS, BUS_nLDS, BUS_RnW,
        input  BUS_D_OUT, BUS_D_OE, BUS_nDTACK_OE
    );

    modport slave (
        input  BUS_A, BUS_D_IN, BUS_nAS, BUS_nUDS, BUS_nLDS, BUS_RnW,
        output BUS_D_OUT, BUS_D_OE, BUS_nDTACK_OE
    );
endinterface

// File: rtl/m68k_bus_responder.sv
// 68000 bus target that terminates cycles hitting a small word mailbox shared with a Pi register port.
// Optional feature: define RESP_IRQ_EN to add the INT_OE / INT_ACK doorbell interrupt pair.
module m68k_bus_responder #(
    parameter logic [23:0] BASE_ADDR = 24'hE90000,
    parameter int unsigned WIN_LOG2  = 3,
    parameter int unsigned ACK_DELAY = 4
) (
    input  logic                SYSCLK,
    input  logic                RESET,
    input  logic                ENABLE,
    m68k_bus_responder_if.slave bus,
    input  logic [WIN_LOG2-1:0] PI_ADDR,
    input  logic [15:0]         PI_WDATA,
    input  logic                PI_WE,
    output logic [15:0]         PI_RDATA,
    output logic                DOORBELL
`ifdef RESP_IRQ_EN
    ,
    output logic                INT_OE,
    input  logic                INT_ACK
`endif
);

    localparam int unsigned         WORDS   = 1 << WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] TOP_IDX = WIN_LOG2'(WORDS - 1);
    localparam logic [3:0]          CNT_INI = 4'(ACK_DELAY - 1);
    localparam bit                  ACK_NOW = (ACK_DELAY <= 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ACCESS,
        S_ACK,
        S_RELEASE
    } state_e;

    // Two-flop synchronizers; bit [1] is the stable copy.
    logic [1:0] nas_sync_q;
    logic [1:0] nuds_sync_q;
    logic [1:0] nlds_sync_q;
    logic [1:0] rnw_sync_q;

    // NOTE: sequential state only ever uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            nas_sync_q  <= 2'b11;
            nuds_sync_q <= 2'b11;
            nlds_sync_q <= 2'b11;
            rnw_sync_q  <= 2'b11;
        end else begin
            nas_sync_q  <= {nas_sync_q[0],  bus.BUS_nAS};
            nuds_sync_q <= {nuds_sync_q[0], bus.BUS_nUDS};
            nlds_sync_q <= {nlds_sync_q[0], bus.BUS_nLDS};
            rnw_sync_q  <= {rnw_sync_q[0],  bus.BUS_RnW};
        end
    end

    logic as_act;
    logic uds_act;
    logic lds_act;
    logic hit;

    assign as_act  = ~nas_sync_q[1];
    assign uds_act = ~nuds_sync_q[1];
    assign lds_act = ~nlds_sync_q[1];
    assign hit     = (bus.BUS_A[23:WIN_LOG2+1] == BASE_ADDR[23:WIN_LOG2+1]);

    state_e              state_q,    state_d;
    logic [WIN_LOG2-1:0] idx_q,      idx_d;
    logic                rnw_q,      rnw_d;
    logic [15:0]         wdata_q,    wdata_d;
    logic                wuds_q,     wuds_d;
    logic                wlds_q,     wlds_d;
    logic [15:0]         dout_q,     dout_d;
    logic                oe_q,       oe_d;
    logic                dtack_q,    dtack_d;
    logic                doorbell_q, doorbell_d;
    logic [3:0]          cnt_q,      cnt_d;
    logic                bus_wr;

    logic [15:0] mbox_q [WORDS];
    logic [15:0] mbox_d [WORDS];

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch appears.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rnw_d      = rnw_q;
        wdata_d    = wdata_q;
        wuds_d     = wuds_q;
        wlds_d     = wlds_q;
        dout_d     = dout_q;
        oe_d       = oe_q;
        dtack_d    = dtack_q;
        cnt_d      = cnt_q;
        doorbell_d = 1'b0;
        bus_wr     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (as_act) begin
                    if (ENABLE && hit) begin
                        state_d = S_DECODE;
                        idx_d   = bus.BUS_A[WIN_LOG2:1];
                        rnw_d   = rnw_sync_q[1];
                    end else begin
                        // Not ours: sit out the cycle without ever driving the bus.
                        state_d = S_RELEASE;
                    end
                end
            end

            S_DECODE: begin
                if (!as_act) begin
                    state_d = S_IDLE;
                end else if (uds_act || lds_act) begin
                    state_d = S_ACCESS;
                    if (rnw_q) begin
                        dout_d = mbox_q[idx_q];
                        oe_d   = 1'b1;
                    end else begin
                        // Write data is valid once the trailing data strobe is seen.
                        wdata_d    = bus.BUS_D_IN;
                        wuds_d     = uds_act;
                        wlds_d     = lds_act;
                        doorbell_d = (idx_q == TOP_IDX);
                    end
                end
            end

            S_ACCESS: begin
                bus_wr = ~rnw_q;
                cnt_d  = CNT_INI;
                if (ACK_NOW) begin
                    dtack_d = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_ACK;
                end
            end

            S_ACK: begin
                if (!as_act) begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end else if (cnt_q == 4'd1) begin
                    dtack_d = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_RELEASE: begin
                if (!as_act) begin
                    oe_d    = 1'b0;
                    dtack_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rnw_q      <= 1'b1;
            wdata_q    <= '0;
            wuds_q     <= 1'b0;
            wlds_q     <= 1'b0;
            dout_q     <= '0;
            oe_q       <= 1'b0;
            dtack_q    <= 1'b0;
            doorbell_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rnw_q      <= rnw_d;
            wdata_q    <= wdata_d;
            wuds_q     <= wuds_d;
            wlds_q     <= wlds_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            dtack_q    <= dtack_d;
            doorbell_q <= doorbell_d;
            cnt_q      <= cnt_d;
        end
    end

    // Bus bytes take priority over a same-cycle Pi write to the same word.
    always_comb begin
        mbox_d = mbox_q;
        if (PI_WE && !(bus_wr && (PI_ADDR == idx_q))) begin
            mbox_d[PI_ADDR] = PI_WDATA;
        end
        if (bus_wr) begin
            if (wuds_q) mbox_d[idx_q][15:8] = wdata_q[15:8];
            if (wlds_q) mbox_d[idx_q][7:0]  = wdata_q[7:0];
        end
    end

    // NOTE: the mailbox is a handful of flops, not a RAM macro, so clearing it on reset is cheap and required.
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < WORDS; i++) begin
                mbox_q[i] <= '0;
            end
        end else begin
            mbox_q <= mbox_d;
        end
    end

`ifdef RESP_IRQ_EN
    logic int_q, int_d;

    // A doorbell in the same cycle as an acknowledge keeps the request pending.
    always_comb begin
        int_d = int_q;
        if (doorbell_q) begin
            int_d = 1'b1;
        end else if (INT_ACK) begin
            int_d = 1'b0;
        end
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            int_q <= 1'b0;
        end else begin
            int_q <= int_d;
        end
    end

    assign INT_OE = int_q;
`endif

    assign bus.BUS_D_OUT     = dout_q;
    assign bus.BUS_D_OE      = oe_q;
    assign bus.BUS_nDTACK_OE = dtack_q;
    assign DOORBELL          = doorbell_q;
    assign PI_RDATA          = mbox_q[PI_ADDR];

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Randomized bench for m68k_bus_responder: a queue-based scoreboard checks every DTACK against a
// word-array model of the mailbox; directed cycles cover byte lanes, misses, aborts and collisions.
module tb_m68k_bus_responder;

    localparam logic [23:0] BASE    = 24'hE90000;
    localparam int          WL2     = 3;
    localparam int          WORDS   = 1 << WL2;
    localparam int          ACK_DLY = 4;
    localparam int          LAT     = 2 + 1 + 1 + ACK_DLY;

    typedef struct {
        int          as_cyc;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    logic           SYSCLK = 1'b0;
    logic           RESET;
    logic           ENABLE;
    logic [WL2-1:0] PI_ADDR;
    logic [15:0]    PI_WDATA;
    logic           PI_WE;
    logic [15:0]    PI_RDATA;
    logic           DOORBELL;
`ifdef RESP_IRQ_EN
    logic           INT_OE;
    logic           INT_ACK;
`endif

    m68k_bus_responder_if bus ();

    m68k_bus_responder #(
        .BASE_ADDR (BASE),
        .WIN_LOG2  (WL2),
        .ACK_DELAY (ACK_DLY)
    ) dut (
        .SYSCLK   (SYSCLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .bus      (bus),
        .PI_ADDR  (PI_ADDR),
        .PI_WDATA (PI_WDATA),
        .PI_WE    (PI_WE),
        .PI_RDATA (PI_RDATA),
        .DOORBELL (DOORBELL)
`ifdef RESP_IRQ_EN
        ,
        .INT_OE   (INT_OE),
        .INT_ACK  (INT_ACK)
`endif
    );

    always #5 SYSCLK = ~SYSCLK;

    int cyc = 0;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model and scoreboard.
    logic [15:0] mbox_m [WORDS];
    bit          en_model;
    int          db_exp = 0;
    exp_t        sb [$];

    // Monitor-side event counters.
    int dt_events = 0;
    int oe_events = 0;
    int db_count  = 0;

    initial begin : monitor
        bit   prev_dt;
        bit   prev_oe;
        exp_t e;
        prev_dt = 1'b0;
        prev_oe = 1'b0;
        forever begin
            @(negedge SYSCLK);
            if (bus.BUS_nDTACK_OE && !prev_dt) begin
                dt_events++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dtack: got DTACK at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("dtack_latency", 32'(cyc - e.as_cyc), 32'(LAT));
                    if (e.rd) begin
                        check("rd_oe_before_dtack", 32'(prev_oe), 32'd1);
                        check("rd_data", 32'(bus.BUS_D_OUT), 32'(e.data));
                    end else begin
                        check("wr_no_oe", 32'(bus.BUS_D_OE), 32'd0);
                    end
                end
            end
            if (bus.BUS_D_OE && !prev_oe) oe_events++;
            if (DOORBELL) db_count++;
            prev_dt = bus.BUS_nDTACK_OE;
            prev_oe = bus.BUS_D_OE;
        end
    end

    task automatic pi_write(input int a, input logic [15:0] d);
        @(negedge SYSCLK);
        PI_ADDR  = WL2'(a);
        PI_WDATA = d;
        PI_WE    = 1'b1;
        @(negedge SYSCLK);
        PI_WE    = 1'b0;
        mbox_m[a] = d;
    endtask

    task automatic readback(input int a);
        @(negedge SYSCLK);
        PI_ADDR = WL2'(a);
        #1;
        check($sformatf("pi_rdata[%0d]", a), 32'(PI_RDATA), 32'(mbox_m[a]));
    endtask

    // One complete bus cycle; expectations come from the window arithmetic and the model array.
    task automatic bus_cycle(input logic [23:0] addr, input bit rd, input bit uds, input bit lds,
                             input logic [15:0] wd, input int ds_dly, input bit abort,
                             input bit collide, input bit drop_en);
        bit   hit;
        bit   claim;
        bit   done;
        int   idx;
        int   n;
        int   dt0;
        int   oe0;
        exp_t e;
        hit   = en_model && (addr >= BASE) && (addr < BASE + 24'(2 * WORDS));
        claim = hit && !abort;
        idx   = hit ? int'((addr - BASE) >> 1) : 0;
        @(negedge SYSCLK);
        ENABLE       = en_model;
        dt0          = dt_events;
        oe0          = oe_events;
        bus.BUS_A    = addr[23:1];
        bus.BUS_RnW  = rd;
        bus.BUS_D_IN = rd ? 16'($urandom) : wd;
        bus.BUS_nAS  = 1'b0;
        if (ds_dly == 0 && !abort) begin
            bus.BUS_nUDS = !uds;
            bus.BUS_nLDS = !lds;
        end
        if (claim) begin
            e.as_cyc = cyc;
            e.rd     = rd;
            e.data   = mbox_m[idx];
            sb.push_back(e);
        end
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge SYSCLK);
            n++;
            PI_WE = 1'b0;
            if (!abort && n == ds_dly) begin
                bus.BUS_nUDS = !uds;
                bus.BUS_nLDS = !lds;
            end
            if (drop_en && n == 4) ENABLE = 1'b0;
            if (collide && DOORBELL) begin
                PI_ADDR  = WL2'(idx);
                PI_WDATA = ~wd;
                PI_WE    = 1'b1;
            end
            if (claim) begin
                if (bus.BUS_nDTACK_OE) begin
                    done = 1'b1;
                end else if (n >= 40) begin
                    check("dtack_seen", 32'(bus.BUS_nDTACK_OE), 32'd1);
                    done = 1'b1;
                end
            end else if (n >= (abort ? 3 : 10)) begin
                done = 1'b1;
            end
        end
        PI_WE        = 1'b0;
        bus.BUS_nAS  = 1'b1;
        bus.BUS_nUDS = 1'b1;
        bus.BUS_nLDS = 1'b1;
        repeat (2) @(negedge SYSCLK);
        if (claim) check("dtack_held", 32'(bus.BUS_nDTACK_OE), 32'd1);
        @(negedge SYSCLK);
        check("dtack_released", 32'(bus.BUS_nDTACK_OE), 32'd0);
        check("oe_released", 32'(bus.BUS_D_OE), 32'd0);
        check("dtack_count", 32'(dt_events - dt0), 32'(claim ? 1 : 0));
        check("oe_count", 32'(oe_events - oe0), 32'((claim && rd) ? 1 : 0));
        if (claim && !rd) begin
            if (uds) mbox_m[idx][15:8] = wd[15:8];
            if (lds) mbox_m[idx][7:0]  = wd[7:0];
            if (idx == WORDS - 1) db_exp++;
        end
        repeat (2) @(negedge SYSCLK);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        RESET        = 1'b1;
        ENABLE       = 1'b0;
        PI_ADDR      = '0;
        PI_WDATA     = '0;
        PI_WE        = 1'b0;
        bus.BUS_A    = '0;
        bus.BUS_D_IN = '0;
        bus.BUS_nAS  = 1'b1;
        bus.BUS_nUDS = 1'b1;
        bus.BUS_nLDS = 1'b1;
        bus.BUS_RnW  = 1'b1;
`ifdef RESP_IRQ_EN
        INT_ACK      = 1'b0;
`endif
        for (int i = 0; i < WORDS; i++) mbox_m[i] = '0;
        en_model = 1'b1;

        #1;
        check("reset_dtack", 32'(bus.BUS_nDTACK_OE), 32'd0);
        check("reset_oe", 32'(bus.BUS_D_OE), 32'd0);
        check("reset_dout", 32'(bus.BUS_D_OUT), 32'd0);
        check("reset_doorbell", 32'(DOORBELL), 32'd0);
        repeat (3) @(negedge SYSCLK);
        RESET = 1'b0;
        for (int i = 0; i < WORDS; i++) readback(i);

        // Word write, byte write, read.
        bus_cycle(24'hE90004, 1'b0, 1'b1, 1'b1, 16'hBEEF, 0, 1'b0, 1'b0, 1'b0);
        readback(2);
        pi_write(3, 16'hAAAA);
        bus_cycle(24'hE90006, 1'b0, 1'b0, 1'b1, 16'h1234, 1, 1'b0, 1'b0, 1'b0);
        readback(3);
        pi_write(5, 16'hC0DE);
        bus_cycle(24'hE9000A, 1'b1, 1'b1, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b0);

        // Miss above the window, then disabled hit.
        bus_cycle(24'hE90010, 1'b1, 1'b1, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        en_model = 1'b0;
        bus_cycle(24'hE90000, 1'b1, 1'b1, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        en_model = 1'b1;

        // Abort before data strobe: nothing written, responder still usable.
        bus_cycle(24'hE90002, 1'b0, 1'b1, 1'b1, 16'hDEAD, 0, 1'b1, 1'b0, 1'b0);
        readback(1);
        bus_cycle(24'hE90002, 1'b1, 1'b1, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 1'b0);

        // Top-word write colliding with a Pi write; ENABLE drops mid-cycle too.
        bus_cycle(24'hE9000E, 1'b0, 1'b1, 1'b1, 16'h5EED, 0, 1'b0, 1'b1, 1'b1);
        readback(7);
        check("doorbell_after_collision", 32'(db_count), 32'(db_exp));
`ifdef RESP_IRQ_EN
        check("int_oe_set", 32'(INT_OE), 32'd1);
        repeat (3) @(negedge SYSCLK);
        check("int_oe_held", 32'(INT_OE), 32'd1);
        INT_ACK = 1'b1;
        @(negedge SYSCLK);
        INT_ACK = 1'b0;
        check("int_oe_cleared", 32'(INT_OE), 32'd0);
`endif

        // Randomized cycles.
        for (int k = 0; k < 60; k++) begin
            int          r;
            logic [23:0] a;
            bit          rd;
            bit          u;
            bit          l;
            bit          ab;
            bit          dr;
            int          dd;
            r = int'($urandom_range(0, 11));
            if (r < 10)       a = BASE + 24'(2 * r);
            else if (r == 10) a = BASE - 24'd2;
            else              a = 24'($urandom) & 24'hFFFFFE;
            rd = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            if (!u && !l) l = 1'b1;
            dd = int'($urandom_range(0, 1));
            ab = ($urandom_range(0, 9) == 0);
            dr = ($urandom_range(0, 3) == 0);
            en_model = ($urandom_range(0, 9) != 0);
            bus_cycle(a, rd, u, l, 16'($urandom), dd, ab, 1'b0, dr);
            if ($urandom_range(0, 1) == 1) pi_write(int'($urandom_range(0, WORDS - 1)), 16'($urandom));
            readback(int'($urandom_range(0, WORDS - 1)));
        end
        en_model = 1'b1;
        for (int i = 0; i < WORDS; i++) readback(i);
        check("doorbell_count", 32'(db_count), 32'(db_exp));

        // Asynchronous reset in the middle of a read cycle.
        pi_write(1, 16'h5A5A);
        @(negedge SYSCLK);
        ENABLE       = 1'b1;
        bus.BUS_A    = 23'(24'hE90002 >> 1);
        bus.BUS_RnW  = 1'b1;
        bus.BUS_nAS  = 1'b0;
        bus.BUS_nUDS = 1'b0;
        bus.BUS_nLDS = 1'b0;
        repeat (6) @(negedge SYSCLK);
        check("mid_read_oe", 32'(bus.BUS_D_OE), 32'd1);
        check("mid_read_data", 32'(bus.BUS_D_OUT), 32'h5A5A);
        #2;
        RESET = 1'b1;
        #1;
        check("async_reset_oe", 32'(bus.BUS_D_OE), 32'd0);
        check("async_reset_dout", 32'(bus.BUS_D_OUT), 32'd0);
        check("async_reset_dtack", 32'(bus.BUS_nDTACK_OE), 32'd0);
        for (int i = 0; i < WORDS; i++) mbox_m[i] = '0;
        bus.BUS_nAS  = 1'b1;
        bus.BUS_nUDS = 1'b1;
        bus.BUS_nLDS = 1'b1;
        repeat (3) @(negedge SYSCLK);
        RESET = 1'b0;
        for (int i = 0; i < WORDS; i++) readback(i);
        bus_cycle(24'hE90008, 1'b0, 1'b1, 1'b0, 16'h77AB, 1, 1'b0, 1'b0, 1'b0);
        readback(4);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
